// File: rtl/mul_div_if.sv
// Handshake and operand bundle between the EX-stage forwarding muxes and the
// iterative multiply/divide unit.
interface mul_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             flush;
    logic [2:0]       op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, flush, op, op_a, op_b,
        input  busy, done, result
    );

    modport slave (
        input  start, flush, op, op_a, op_b,
        output busy, done, result
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M-style multiply/divide: sign-magnitude operands, one shift-add
// or restoring-divide step per cycle, sign fix-up folded into the last step.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    mul_div_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, CALC} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [2:0]         op_reg, op_next;
    logic               neg_reg, neg_next;
    logic [WIDTH-1:0]   b_reg, b_next;
    logic [2*WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH:0]     rem_reg, rem_next;
    logic [WIDTH-1:0]   result_reg, result_next;
    logic               done_reg, done_next;

    logic             a_signed, b_signed, sign_a, sign_b, b_zero, is_div_in, neg_in;
    logic [WIDTH-1:0] a_abs, b_abs;

    always_comb begin
        a_signed  = (bus.op == 3'b001) || (bus.op == 3'b010) ||
                    (bus.op == 3'b100) || (bus.op == 3'b110);
        b_signed  = (bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110);
        sign_a    = a_signed & bus.op_a[WIDTH-1];
        sign_b    = b_signed & bus.op_b[WIDTH-1];
        is_div_in = bus.op[2];
        b_zero    = (bus.op_b == '0);
        // A zero divisor makes the restoring loop shift A straight into the
        // remainder, so keeping A raw yields the required remainder for free.
        a_abs     = (sign_a && !(is_div_in && b_zero)) ? -bus.op_a : bus.op_a;
        b_abs     = sign_b ? -bus.op_b : bus.op_b;
        if (is_div_in && b_zero) begin
            neg_in = 1'b0;
        end else if (is_div_in && bus.op[1]) begin
            neg_in = sign_a;
        end else begin
            neg_in = sign_a ^ sign_b;
        end
    end

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step, prod_fix;
    logic [WIDTH+1:0]   rem_shift, diff;
    logic [WIDTH:0]     rem_step;
    logic [WIDTH-1:0]   q_step, div_raw, div_fix, final_value;

    always_comb begin
        mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, b_reg} : '0);
        mul_step  = {mul_sum, acc_reg[WIDTH-1:1]};
        rem_shift = {rem_reg, acc_reg[WIDTH-1]};
        diff      = rem_shift - {2'b00, b_reg};
        if (diff[WIDTH+1]) begin
            rem_step = rem_shift[WIDTH:0];
            q_step   = {acc_reg[WIDTH-2:0], 1'b0};
        end else begin
            rem_step = diff[WIDTH:0];
            q_step   = {acc_reg[WIDTH-2:0], 1'b1};
        end
        prod_fix = neg_reg ? -mul_step : mul_step;
        div_raw  = op_reg[1] ? rem_step[WIDTH-1:0] : q_step;
        div_fix  = neg_reg ? -div_raw : div_raw;
        if (op_reg[2]) begin
            final_value = div_fix;
        end else if (op_reg[1:0] == 2'b00) begin
            final_value = prod_fix[WIDTH-1:0];
        end else begin
            final_value = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        op_next     = op_reg;
        neg_next    = neg_reg;
        b_next      = b_reg;
        acc_next    = acc_reg;
        rem_next    = rem_reg;
        result_next = result_reg;
        done_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    op_next    = bus.op;
                    neg_next   = neg_in;
                    b_next     = b_abs;
                    acc_next   = {{WIDTH{1'b0}}, a_abs};
                    rem_next   = '0;
                    cnt_next   = '0;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_next = IDLE;
                end else begin
                    // Divide keeps the quotient in the low half of the accumulator.
                    acc_next = op_reg[2] ? {acc_reg[2*WIDTH-1:WIDTH], q_step} : mul_step;
                    rem_next = op_reg[2] ? rem_step : rem_reg;
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST) begin
                        state_next  = IDLE;
                        done_next   = 1'b1;
                        result_next = final_value;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            op_reg     <= '0;
            neg_reg    <= 1'b0;
            b_reg      <= '0;
            acc_reg    <= '0;
            rem_reg    <= '0;
            result_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            op_reg     <= op_next;
            neg_reg    <= neg_next;
            b_reg      <= b_next;
            acc_reg    <= acc_next;
            rem_reg    <= rem_next;
            result_reg <= result_next;
            done_reg   <= done_next;
        end
    end

    assign bus.busy   = (state_reg == CALC);
    assign bus.done   = done_reg;
    assign bus.result = result_reg;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: results, latency, flush, reset and
// back-to-back behaviour against hand-computed values.
module tb_mul_div_unit;
    localparam int WIDTH = 32;
    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_div_if #(.WIDTH(WIDTH)) bus ();
    mul_div_unit #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present a start for one edge, then scramble the operands (don't-care).
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = o;
        bus.op_a  = a;
        bus.op_b  = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.op_a  = $urandom;
        bus.op_b  = $urandom;
    endtask

    // Called 1 ns after the start edge; returns 1 ns after the done edge.
    task automatic wait_done(input string tag, input logic [31:0] exp);
        int lat = 1;
        bit seen = 0;
        check({tag, "_busy"}, {31'b0, bus.busy}, 32'd1);
        while (!seen && lat <= 40) begin
            @(posedge clk); #1;
            if (bus.done) seen = 1;
            else lat++;
        end
        $display("[TB] %s result=0x%08h latency=%0d", tag, bus.result, lat);
        check({tag, "_lat"}, lat, 32'd32);
        check({tag, "_res"}, bus.result, exp);
        check({tag, "_busy_at_done"}, {31'b0, bus.busy}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        issue(o, a, b);
        wait_done(tag, exp);
        @(posedge clk); #1;
        check({tag, "_done_drop"}, {31'b0, bus.done}, 32'd0);
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (bus.done) n++;
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bus.start = 1'b0; bus.flush = 1'b0; bus.op = 3'b000;
        bus.op_a = '0; bus.op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_result", bus.result, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("mul",     MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB);
        run_op("mulh",    MULH,   32'h80000000,   32'h80000000, 32'h40000000);
        run_op("mulhu",   MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("mulhsu",  MULHSU, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF);
        run_op("mulh_m1", MULH,   32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000);
        run_op("div",     DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD);
        run_op("rem",     REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF);
        run_op("divu",    DIVU,   32'd100,        32'd7,        32'd14);
        run_op("remu",    REMU,   32'd100,        32'd7,        32'd2);
        run_op("div_z",   DIV,    32'd5,          32'd0,        32'hFFFFFFFF);
        run_op("rem_z",   REM,    32'hFFFFFFFB,   32'd0,        32'hFFFFFFFB);
        run_op("remu_z",  REMU,   32'd5,          32'd0,        32'd5);
        run_op("div_ovf", DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000);
        run_op("rem_ovf", REM,    32'h80000000,   32'hFFFFFFFF, 32'h00000000);

        // Flush a DIV in its tenth cycle; the previous result (2) must survive.
        run_op("pre_flush", REMU, 32'd100, 32'd7, 32'd2);
        issue(DIV, 32'hFFFFFFF9, 32'd2);
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_busy", {31'b0, bus.busy}, 32'd0);
        check("flush_done", {31'b0, bus.done}, 32'd0);
        count_dones(40, n);
        check("flush_no_done", n, 32'd0);
        check("flush_result", bus.result, 32'd2);
        $display("[TB] flush mid-DIV dones=%0d result=0x%08h", n, bus.result);

        bus.start = 1'b1; bus.flush = 1'b1; bus.op = DIVU;
        bus.op_a = 32'd100; bus.op_b = 32'd9;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        check("sf_busy", {31'b0, bus.busy}, 32'd0);
        count_dones(35, n);
        check("sf_no_done", n, 32'd0);
        check("sf_result", bus.result, 32'd2);
        $display("[TB] start+flush in idle dones=%0d", n);

        // Start held high through busy: only the first operation completes.
        bus.start = 1'b1; bus.op = DIVU; bus.op_a = 32'd100; bus.op_b = 32'd7;
        @(posedge clk); #1;
        bus.op = MUL; bus.op_a = 32'd3; bus.op_b = 32'd3;
        wait_done("held", 32'd14);
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("held_idle", {31'b0, bus.busy}, 32'd0);

        // Back-to-back: second start presented during the done cycle.
        issue(MUL, 32'd7, 32'hFFFFFFFD);
        wait_done("b2b_1", 32'hFFFFFFEB);
        issue(DIVU, 32'd100, 32'd7);
        wait_done("b2b_2", 32'd14);
        @(posedge clk); #1;

        // Asynchronous reset mid-CALC clears outputs before the next edge.
        issue(MUL, 32'd7, 32'd6);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", {31'b0, bus.busy}, 32'd0);
        check("arst_done", {31'b0, bus.done}, 32'd0);
        check("arst_result", bus.result, 32'd0);
        $display("[TB] async reset mid-CALC busy=%0b result=0x%08h", bus.busy, bus.result);
        @(posedge clk); #1;
        rst = 1'b0;
        run_op("post_rst", MUL, 32'd7, 32'd6, 32'd42);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
